// File: rtl/csi2tx_pkg.sv
// rtl/csi2tx_pkg.sv - shared constants and helpers for the CSI-2 TX low-level packet tracker
package csi2tx_pkg;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACTIVE = 2'b01;
    localparam logic [1:0] DONE   = 2'b10;

    localparam int unsigned SHORT_PKT_BYTES = 4;
    localparam int unsigned PH_PF_BYTES     = 6;
    localparam int unsigned FIFO_WORD_BYTES = 8;

    localparam logic [5:0]  SHORT_DT_MAX = 6'h0F;
    localparam logic [16:0] RD_CNT_MAX   = 17'h1FFFF;

    // Bytes on the wire for a packet: a short packet is only its 4-byte header,
    // a long packet adds the payload (WC bytes) and the 2-byte footer.
    function automatic logic [16:0] pkt_byte_total(input logic [5:0] dt, input logic [15:0] wc);
        if (dt <= SHORT_DT_MAX) begin
            return 17'(SHORT_PKT_BYTES);
        end
        return 17'(PH_PF_BYTES) + {1'b0, wc};
    endfunction

endpackage

// File: rtl/csi2tx_ldl_pkt_tracker_if.sv
// rtl/csi2tx_ldl_pkt_tracker_if.sv - FIFO, lane and status signals of the packet tracker
interface csi2tx_ldl_pkt_tracker_if;
    logic        forcetxstopmode;
    logic        fifo_rd_en;
    logic [63:0] fifo_dout;
    logic        header_info;
    logic [7:0]  txrequesths;
    logic [7:0]  txreadyhs;
    logic [63:0] fifo_rd_data;
    logic [63:0] fifo_rd_data_d;
    logic        short_packet;
    logic [16:0] validated_word_cnt;
    logic        eop_rd;
    logic        eop_wr;

    modport master (
        output forcetxstopmode, fifo_rd_en, fifo_dout, header_info, txrequesths, txreadyhs,
        input  fifo_rd_data, fifo_rd_data_d, short_packet, validated_word_cnt, eop_rd, eop_wr
    );

    modport slave (
        input  forcetxstopmode, fifo_rd_en, fifo_dout, header_info, txrequesths, txreadyhs,
        output fifo_rd_data, fifo_rd_data_d, short_packet, validated_word_cnt, eop_rd, eop_wr
    );
endinterface

// File: rtl/csi2tx_lane_popcount.sv
// rtl/csi2tx_lane_popcount.sv - number of lanes requesting HS in a cycle
module csi2tx_lane_popcount (
    input  logic [7:0] lanes_i,
    output logic [3:0] cnt_o
);

    // Sum the per-lane request bits.
    always_comb begin
        cnt_o = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt_o = cnt_o + {3'b000, lanes_i[i]};
        end
    end

endmodule

// File: rtl/csi2tx_ldl_pkt_tracker.sv
// rtl/csi2tx_ldl_pkt_tracker.sv - tracks bytes read from the FIFO and accepted by the PHY per packet
module csi2tx_ldl_pkt_tracker
    import csi2tx_pkg::*;
(
    input  logic                      txbyteclkhs,
    input  logic                      txbyteclkhs_rst_n,
    csi2tx_ldl_pkt_tracker_if.slave   bus
);

    logic [1:0]  state_q, state_d;
    logic        rd_d_q;
    logic [63:0] rd_data_q, rd_data_d_q;
    logic        short_q, short_d;
    logic [16:0] total_q, total_d;
    logic [16:0] cnt_q, cnt_d;
    logic [16:0] rd_cnt_q, rd_cnt_d;
    logic        eop_rd_q, eop_wr_q;
    logic [3:0]  lane_cnt;
    logic        beat;
    logic        unused_rdy;

    // Only lane 0 ready qualifies a beat; the other ready bits are ignored.
    assign unused_rdy = ^bus.txreadyhs[7:1];

    csi2tx_lane_popcount u_popcount (
        .lanes_i (bus.txrequesths),
        .cnt_o   (lane_cnt)
    );

    assign beat = (state_q == ACTIVE) && bus.txreadyhs[0] && bus.txrequesths[0];

    // Next-state: header reloads everything, beats drain the PHY count, reads grow the FIFO count.
    always_comb begin
        state_d  = state_q;
        short_d  = short_q;
        total_d  = total_q;
        cnt_d    = cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (bus.header_info) begin
            state_d  = ACTIVE;
            short_d  = (bus.fifo_dout[5:0] <= SHORT_DT_MAX);
            total_d  = pkt_byte_total(bus.fifo_dout[5:0], bus.fifo_dout[23:8]);
            cnt_d    = total_d;
            rd_cnt_d = 17'(FIFO_WORD_BYTES);
        end else if (state_q == ACTIVE) begin
            if (beat) begin
                cnt_d = (cnt_q > {13'd0, lane_cnt}) ? cnt_q - {13'd0, lane_cnt} : 17'd0;
                if (cnt_d == 17'd0) begin
                    state_d = DONE;
                end
            end
            if (bus.fifo_rd_en) begin
                rd_cnt_d = (rd_cnt_q > RD_CNT_MAX - 17'(FIFO_WORD_BYTES)) ?
                           RD_CNT_MAX : rd_cnt_q + 17'(FIFO_WORD_BYTES);
            end
        end else if ((state_q == DONE) && (bus.txrequesths == 8'h00)) begin
            state_d = IDLE;
        end
    end

    // Packet tracking registers; abort clears them like reset.
    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            state_q  <= IDLE;
            short_q  <= 1'b0;
            total_q  <= 17'd0;
            cnt_q    <= 17'd0;
            rd_cnt_q <= 17'd0;
            eop_rd_q <= 1'b0;
            eop_wr_q <= 1'b0;
        end else if (bus.forcetxstopmode) begin
            state_q  <= IDLE;
            short_q  <= 1'b0;
            total_q  <= 17'd0;
            cnt_q    <= 17'd0;
            rd_cnt_q <= 17'd0;
            eop_rd_q <= 1'b0;
            eop_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            short_q  <= short_d;
            total_q  <= total_d;
            cnt_q    <= cnt_d;
            rd_cnt_q <= rd_cnt_d;
            eop_rd_q <= (state_q == ACTIVE) && (rd_cnt_q >= total_q);
            eop_wr_q <= (state_d == DONE);
        end
    end

    // Two-deep staging of FIFO words, loaded the cycle after each read strobe.
    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            rd_d_q      <= 1'b0;
            rd_data_q   <= 64'd0;
            rd_data_d_q <= 64'd0;
        end else if (bus.forcetxstopmode) begin
            rd_d_q      <= 1'b0;
            rd_data_q   <= 64'd0;
            rd_data_d_q <= 64'd0;
        end else begin
            rd_d_q <= bus.fifo_rd_en;
            if (rd_d_q) begin
                rd_data_q   <= bus.fifo_dout;
                rd_data_d_q <= rd_data_q;
            end
        end
    end

    assign bus.fifo_rd_data       = rd_data_q;
    assign bus.fifo_rd_data_d     = rd_data_d_q;
    assign bus.short_packet       = short_q;
    assign bus.validated_word_cnt = cnt_q;
    assign bus.eop_rd             = eop_rd_q;
    assign bus.eop_wr             = eop_wr_q;

endmodule

// File: tb/tb_csi2tx_ldl_pkt_tracker.sv
// tb/tb_csi2tx_ldl_pkt_tracker.sv - scoreboard bench for the packet tracker
module tb_csi2tx_ldl_pkt_tracker;

    typedef struct {
        logic [63:0] d;
        logic [63:0] dd;
        logic        sp;
        logic [16:0] cnt;
        logic        er;
        logic        ew;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t q[$];

    csi2tx_ldl_pkt_tracker_if bus();

    csi2tx_ldl_pkt_tracker dut (
        .txbyteclkhs       (clk),
        .txbyteclkhs_rst_n (rst_n),
        .bus               (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: packet phase 0=no packet, 1=sending, 2=all bytes sent
    int          m_phase;
    longint      m_left;
    longint      m_read;
    longint      m_total;
    logic        m_short;
    logic [63:0] m_data, m_data_d;
    logic        m_pend;
    logic        m_er, m_ew;

    task automatic model_clear();
        m_phase = 0; m_left = 0; m_read = 0; m_total = 0; m_short = 1'b0;
        m_data = '0; m_data_d = '0; m_pend = 1'b0; m_er = 1'b0; m_ew = 1'b0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.d = m_data; e.dd = m_data_d; e.sp = m_short;
        e.cnt = 17'(m_left); e.er = m_er; e.ew = m_ew;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".fifo_rd_data"},       bus.fifo_rd_data,                e.d);
        chk({tag, ".fifo_rd_data_d"},     bus.fifo_rd_data_d,              e.dd);
        chk({tag, ".short_packet"},       64'(bus.short_packet),           64'(e.sp));
        chk({tag, ".validated_word_cnt"}, 64'(bus.validated_word_cnt),     64'(e.cnt));
        chk({tag, ".eop_rd"},             64'(bus.eop_rd),                 64'(e.er));
        chk({tag, ".eop_wr"},             64'(bus.eop_wr),                 64'(e.ew));
    endtask

    // Monitor: compares every presented output set against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_all("mon", e);
            end
        end
    end

    // Drive one cycle of inputs and push what the outputs must be after the next edge.
    task automatic step(input logic hi, input logic [63:0] dout, input logic rd,
                        input logic [7:0] req, input logic [7:0] rdy, input logic stop);
        logic   new_er;
        longint wc;
        @(negedge clk);
        bus.header_info = hi; bus.fifo_dout = dout; bus.fifo_rd_en = rd;
        bus.txrequesths = req; bus.txreadyhs = rdy; bus.forcetxstopmode = stop;
        if (stop) begin
            model_clear();
        end else begin
            new_er = (m_phase == 1) && (m_read >= m_total);
            if (m_pend) begin
                m_data_d = m_data;
                m_data   = dout;
            end
            m_pend = rd;
            if (hi) begin
                wc      = longint'(dout[23:8]);
                m_short = (dout[5:0] < 6'd16);
                m_total = m_short ? 4 : wc + 6;
                m_left  = m_total;
                m_read  = 8;
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (req[0] && rdy[0]) begin
                    m_left = m_left - longint'($countones(req));
                    if (m_left < 0) m_left = 0;
                    if (m_left == 0) m_phase = 2;
                end
                if (rd) begin
                    m_read = m_read + 8;
                    if (m_read > 131071) m_read = 131071;
                end
            end else if (m_phase == 2 && req == 8'h00) begin
                m_phase = 0;
            end
            m_er = new_er;
            m_ew = (m_phase == 2);
        end
        q.push_back(model_out());
    endtask

    task automatic idle();
        step(1'b0, 64'h0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    function automatic logic [63:0] hdr(input logic [5:0] dt, input logic [15:0] wc);
        return {$urandom, 8'h00, wc, 2'b01, dt};
    endfunction

    initial begin
        logic [7:0]  req_tab [7];
        logic [5:0]  dt_tab  [5];
        logic [7:0]  req;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic        hi;
        checks = 0;
        errors = 0;
        req_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'hFF, 8'h00, 8'h05};
        dt_tab  = '{6'h01, 6'h0F, 6'h10, 6'h2A, 6'h3F};
        rst_n = 1'b0;
        bus.header_info = 0; bus.fifo_dout = '0; bus.fifo_rd_en = 0;
        bus.txrequesths = 0; bus.txreadyhs = 0; bus.forcetxstopmode = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", model_out());
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // short packet, DT=01, two 3-lane beats: 4 -> 1 -> 0
        step(1'b1, 64'h5A000001, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b0, 64'h0, 1'b0, 8'h07, 8'h01, 1'b0);
        step(1'b0, 64'h0, 1'b0, 8'h07, 8'h01, 1'b0);
        step(1'b0, 64'h0, 1'b0, 8'h07, 8'h01, 1'b0);
        idle(); idle();

        // long packet DT=2A WC=10, one FIFO read, six 3-lane beats
        step(1'b1, 64'h00000A2A, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b0, 64'h0, 1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b0, 64'h1111, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (6) step(1'b0, 64'h0, 1'b0, 8'h07, 8'h01, 1'b0);
        idle(); idle();

        // staging: A then B, then non-read cycles with other data on the bus
        step(1'b0, 64'h0, 1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b0, 64'hAAAA_0000_AAAA_0001, 1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b0, 64'hBBBB_0000_BBBB_0002, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) step(1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 8'h00, 8'h00, 1'b0);

        // abort with count 7, then a fresh packet
        step(1'b1, 64'h00000A2A, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) step(1'b0, 64'h0, 1'b0, 8'h07, 8'h01, 1'b0);
        step(1'b0, 64'h0, 1'b1, 8'h07, 8'h00, 1'b1);
        step(1'b1, 64'h5A000001, 1'b0, 8'h00, 8'h00, 1'b0);
        idle();

        // collision: beat and long WC=0 header together
        step(1'b1, 64'h0000002A, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 64'h0000002A, 1'b0, 8'h07, 8'h01, 1'b0);
        idle();

        // asynchronous reset mid-packet
        step(1'b1, 64'h00000A2A, 1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b0, 64'h1234, 1'b0, 8'h03, 8'h01, 1'b0);
        @(negedge clk);
        bus.header_info = 0; bus.fifo_rd_en = 0; bus.txrequesths = 0;
        bus.txreadyhs = 0; bus.forcetxstopmode = 0;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk_all("async_rst", model_out());
        q.push_back(model_out());
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            hi = ($urandom_range(0, 29) == 0) || ((m_phase == 0) && ($urandom_range(0, 3) == 0));
            dt = dt_tab[$urandom_range(0, 4)];
            wc = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(0, 30));
            req = ($urandom_range(0, 4) == 0) ? 8'($urandom) : req_tab[$urandom_range(0, 6)];
            step(hi, hi ? hdr(dt, wc) : {$urandom, $urandom}, 1'($urandom),
                 req, 8'($urandom), $urandom_range(0, 149) == 0);
        end
        idle(); idle();

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
